// File: rtl/sat_pkg.sv
// Shared types for the SAT sweep block: FSM states, streamed-literal record and a
// constant-evaluable clog2.
package sat_pkg;

  localparam int VIDX_W = 5;  // variable index width after range folding (NUM_VARS <= 32)

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STREAM,
    EVAL,
    DONE
  } state_t;

  typedef struct packed {
    logic [VIDX_W-1:0] lvar;
    logic              neg;
    logic              last_clause;
    logic              last_cnf;
  } lit_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/sat_lane.sv
// One evaluation lane: tracks the running clause OR and formula AND for the candidate
// assignment {base, LANE_IDX} while the host streams literals.
module sat_lane
  import sat_pkg::*;
#(
  parameter int NUM_VARS = 5,
  parameter int VAR_W    = 5,
  parameter int LANE_IDX = 0
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic [NUM_VARS-1:0] base_bits,
  input  lit_t                lit,
  input  logic                hs,
  input  logic                pass_init,
  output logic                cnf_acc
);

  logic        clause_acc;
  logic [31:0] cand;
  logic        val;

  // Low bits of base_bits are always zero, so OR-ing in the lane index forms the candidate.
  assign cand = 32'(base_bits) | 32'(LANE_IDX);
  assign val  = cand[lit.lvar] ^ lit.neg;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      clause_acc <= 1'b0;
      cnf_acc    <= 1'b0;
    end else if (pass_init) begin
      clause_acc <= 1'b0;
      cnf_acc    <= 1'b1;
    end else if (hs) begin
      if (lit.last_clause | lit.last_cnf) begin
        cnf_acc    <= cnf_acc & (clause_acc | val);
        clause_acc <= 1'b0;
      end else begin
        clause_acc <= clause_acc | val;
      end
    end
  end

endmodule

// File: rtl/sat_sweep_top.sv
// Multi-pass brute-force CNF evaluator: NUM_ACC lanes test consecutive assignments per
// pass, the base counter sweeps passes until a lane satisfies the formula or all are tried.
module sat_sweep_top
  import sat_pkg::*;
#(
  parameter  int NUM_ACC  = 4,
  parameter  int NUM_VARS = 5,
  parameter  int VAR_W    = 5,
  localparam int LG       = clog2(NUM_ACC),
  localparam int PASS_W   = NUM_VARS - LG,
  localparam int PB       = (PASS_W > 0) ? PASS_W : 1
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                start,
  input  logic                abort,
  input  logic                lit_valid,
  output logic                lit_ready,
  input  logic [VAR_W-1:0]    lit_var,
  input  logic                lit_neg,
  input  logic                lit_last_clause,
  input  logic                lit_last_cnf,
  output logic                pass_req,
  output logic                busy,
  output logic                done,
  output logic                sat,
  output logic [NUM_VARS-1:0] sat_assign,
  output logic [PASS_W:0]     pass_cnt
);

  state_t              state, nxt;
  logic [PB-1:0]       base;
  logic [NUM_ACC-1:0]  cnf;
  logic [LG-1:0]       win;
  logic [NUM_VARS-1:0] base_bits;
  logic [31:0]         lv32;
  lit_t                lit;
  logic                any_sat, last_pass, hs, pass_init;

  // Out-of-range variable indices fold to variable 0.
  assign lv32 = 32'(lit_var);
  assign lit  = '{lvar:        (lv32 < 32'(NUM_VARS)) ? lv32[VIDX_W-1:0] : '0,
                  neg:         lit_neg,
                  last_clause: lit_last_clause,
                  last_cnf:    lit_last_cnf};

  assign hs        = lit_valid & lit_ready;
  assign base_bits = NUM_VARS'(32'(base) << LG);
  assign last_pass = (PASS_W == 0) || (&base);
  assign any_sat   = |cnf;

  for (genvar i = 0; i < NUM_ACC; i++) begin : g_lane
    sat_lane #(.NUM_VARS(NUM_VARS), .VAR_W(VAR_W), .LANE_IDX(i)) u_lane (
      .clk       (clk),
      .resetN    (resetN),
      .base_bits (base_bits),
      .lit       (lit),
      .hs        (hs),
      .pass_init (pass_init),
      .cnf_acc   (cnf[i])
    );
  end

  // Lowest satisfying lane wins.
  always_comb begin
    win = '0;
    for (int i = NUM_ACC - 1; i >= 0; i--)
      if (cnf[i]) win = LG'(i);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt       = state;
    lit_ready = 1'b0;
    pass_req  = 1'b0;
    busy      = 1'b0;
    pass_init = 1'b0;
    case (state)
      IDLE:   if (start) nxt = SETUP;
      SETUP: begin
        busy      = 1'b1;
        pass_req  = 1'b1;
        pass_init = 1'b1;
        nxt       = STREAM;
      end
      STREAM: begin
        busy      = 1'b1;
        lit_ready = 1'b1;
        if (hs && lit.last_cnf) nxt = EVAL;
      end
      EVAL: begin
        busy = 1'b1;
        if (any_sat || last_pass) begin
          nxt = DONE;
        end else begin
          pass_req  = 1'b1;
          pass_init = 1'b1;
          nxt       = STREAM;
        end
      end
      DONE:   if (start) nxt = SETUP;
      default: nxt = IDLE;
    endcase
    if (abort) begin
      nxt       = IDLE;
      pass_req  = 1'b0;
      pass_init = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      base       <= '0;
      done       <= 1'b0;
      sat        <= 1'b0;
      sat_assign <= '0;
      pass_cnt   <= '0;
    end else if (abort) begin
      done <= 1'b0;
      sat  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          done <= 1'b0;
          sat  <= 1'b0;
        end
        SETUP: begin
          base     <= '0;
          pass_cnt <= '0;
        end
        EVAL: begin
          pass_cnt <= pass_cnt + 1'b1;
          if (any_sat) begin
            sat        <= 1'b1;
            sat_assign <= base_bits | NUM_VARS'(win);
            done       <= 1'b1;
          end else if (last_pass) begin
            sat  <= 1'b0;
            done <= 1'b1;
          end else begin
            base <= base + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sat_sweep_top.sv
// Directed bench for sat_sweep_top: three instances (NUM_VARS 2/4/3, NUM_ACC 4) sharing
// the literal bus, each with its own valid/start/abort.
module tb_sat_sweep_top;

  typedef logic [5:0] flit_t;  // {last_cnf, last_clause, neg, var[2:0]}

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [2:0] start = '0, abort = '0, lit_valid = '0;
  logic [2:0] lit_var = '0;
  logic       lit_neg = 1'b0, lit_lc = 1'b0, lit_lcnf = 1'b0;
  logic [2:0] lit_ready, pass_req, busy, done, sat;
  logic [3:0] sa_w [3];
  logic [2:0] pc_w [3];
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NV = (g == 0) ? 2 : (g == 1) ? 4 : 3;
    logic [NV-1:0] sa;
    logic [NV-2:0] pc;
    sat_sweep_top #(.NUM_ACC(4), .NUM_VARS(NV), .VAR_W(3)) u_dut (
      .clk             (clk),
      .resetN          (resetN),
      .start           (start[g]),
      .abort           (abort[g]),
      .lit_valid       (lit_valid[g]),
      .lit_ready       (lit_ready[g]),
      .lit_var         (lit_var),
      .lit_neg         (lit_neg),
      .lit_last_clause (lit_lc),
      .lit_last_cnf    (lit_lcnf),
      .pass_req        (pass_req[g]),
      .busy            (busy[g]),
      .done            (done[g]),
      .sat             (sat[g]),
      .sat_assign      (sa),
      .pass_cnt        (pc)
    );
    assign sa_w[g] = 4'(sa);
    assign pc_w[g] = 3'(pc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_lit(input int d, input flit_t l, input bit bp);
    logic rdy;
    int   n;
    n = 0;
    if (bp && $urandom_range(0, 1) == 1) begin
      lit_valid[d] = 1'b0;
      {lit_lcnf, lit_lc, lit_neg, lit_var} = 6'($urandom);
      tick();
    end
    {lit_lcnf, lit_lc, lit_neg, lit_var} = l;
    lit_valid[d] = 1'b1;
    do begin
      rdy = lit_ready[d];
      tick();
      n++;
    end while (!rdy && n < 50);
    lit_valid[d] = 1'b0;
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL handshake_timeout dut=%0d: lit_ready never high, required 1", d);
    end
  endtask

  task automatic run_sweep(input int d, input flit_t f[$], input bit bp,
                           output int npr, output int ok);
    int cyc;
    cyc = 0; npr = 0; ok = 0;
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    while (cyc < 400) begin
      if (done[d]) begin
        ok = 1;
        break;
      end
      if (pass_req[d]) begin
        npr++;
        foreach (f[k]) send_lit(d, f[k], bp);
      end else begin
        tick();
        cyc++;
      end
    end
    if (ok == 0) begin
      checks++; errors++;
      $display("FAIL sweep_timeout dut=%0d: done=0, required 1", d);
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({lit_ready[d], pass_req[d], busy[d], done[d], sat[d], sa_w[d], pc_w[d]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs dut=%0d: rdy=%b preq=%b busy=%b done=%b sat=%b sa=%h pc=%0d, required all 0",
                 d, lit_ready[d], pass_req[d], busy[d], done[d], sat[d], sa_w[d], pc_w[d]);
      end
    end
    resetN = 1'b1;
    tick();
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    tick();
    send_lit(1, 6'b000000, 1'b0);
    checks++;
    if (lit_ready[1] !== 1'b1 || busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_stream dut=1: rdy=%b busy=%b, required 1 1", lit_ready[1], busy[1]);
    end
    #2 resetN = 1'b0;
    #1;
    checks++;
    if ({lit_ready[1], pass_req[1], busy[1], done[1], sat[1], sa_w[1], pc_w[1]} !== '0) begin
      errors++;
      $display("FAIL async_reset dut=1: rdy=%b preq=%b busy=%b done=%b, required all 0",
               lit_ready[1], pass_req[1], busy[1], done[1]);
    end
    tick();
    resetN = 1'b1;
    tick();
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    checks++;
    if (pass_req[1] !== 1'b1) begin
      errors++;
      $display("FAIL restart_pass_req dut=1: pass_req=%b, required 1", pass_req[1]);
    end
    abort[1] = 1'b1; tick(); abort[1] = 1'b0;
    checks++;
    if (busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL abort_setup dut=1: busy=%b, required 0", busy[1]);
    end
  endtask

  task automatic test_single_pass();
    flit_t f[$];
    int npr, ok;
    f = '{6'b010000, 6'b111001};  // (x0) & (~x1)
    run_sweep(0, f, 1'b0, npr, ok);
    checks++;
    if (sat[0] !== 1'b1 || sa_w[0] !== 4'b0001 || pc_w[0] !== 3'd1 || npr != 1) begin
      errors++;
      $display("FAIL single_pass: sat=%b sa=%b pc=%0d npr=%0d, required 1 0001 1 1",
               sat[0], sa_w[0], pc_w[0], npr);
    end
  endtask

  task automatic test_multi_pass();
    flit_t f[$];
    int npr, ok;
    f = '{6'b010011, 6'b010010, 6'b111000};  // (x3) & (x2) & (~x0)
    run_sweep(1, f, 1'b0, npr, ok);
    checks++;
    if (sat[1] !== 1'b1 || sa_w[1] !== 4'b1100 || pc_w[1] !== 3'd4 || npr != 4) begin
      errors++;
      $display("FAIL multi_pass: sat=%b sa=%b pc=%0d npr=%0d, required 1 1100 4 4",
               sat[1], sa_w[1], pc_w[1], npr);
    end
  endtask

  task automatic test_unsat();
    flit_t f[$];
    int npr, ok;
    f = '{6'b010000, 6'b111000};  // (x0) & (~x0)
    run_sweep(2, f, 1'b0, npr, ok);
    checks++;
    if (done[2] !== 1'b1 || sat[2] !== 1'b0 || pc_w[2] !== 3'd2 || npr != 2) begin
      errors++;
      $display("FAIL unsat: done=%b sat=%b pc=%0d npr=%0d, required 1 0 2 2",
               done[2], sat[2], pc_w[2], npr);
    end
  endtask

  task automatic test_back_to_back();
    flit_t f[$];
    int npr, ok;
    f = '{6'b000000, 6'b100001};  // (x0 | x1), closed only by last_cnf
    run_sweep(1, f, 1'b1, npr, ok);
    checks++;
    if (sat[1] !== 1'b1 || sa_w[1] !== 4'b0001 || pc_w[1] !== 3'd1 || npr != 1) begin
      errors++;
      $display("FAIL backpressure_lowest: sat=%b sa=%b pc=%0d npr=%0d, required 1 0001 1 1",
               sat[1], sa_w[1], pc_w[1], npr);
    end
    tick(); tick(); tick();
    checks++;
    if (done[1] !== 1'b1 || sat[1] !== 1'b1 || sa_w[1] !== 4'b0001 || busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: done=%b sat=%b sa=%b busy=%b, required 1 1 0001 0",
               done[1], sat[1], sa_w[1], busy[1]);
    end
    f = '{6'b110111};  // var 7 >= NUM_VARS reads as x0
    run_sweep(2, f, 1'b1, npr, ok);
    checks++;
    if (sat[2] !== 1'b1 || sa_w[2] !== 4'b0001 || pc_w[2] !== 3'd1) begin
      errors++;
      $display("FAIL var_out_of_range: sat=%b sa=%b pc=%0d, required 1 0001 1",
               sat[2], sa_w[2], pc_w[2]);
    end
  endtask

  task automatic test_abort();
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    send_lit(1, 6'b010000, 1'b0);
    abort[1] = 1'b1; tick(); abort[1] = 1'b0;
    checks++;
    if (busy[1] !== 1'b0 || lit_ready[1] !== 1'b0 || done[1] !== 1'b0) begin
      errors++;
      $display("FAIL abort_stream: busy=%b rdy=%b done=%b, required 0 0 0",
               busy[1], lit_ready[1], done[1]);
    end
    lit_valid[1] = 1'b1;
    {lit_lcnf, lit_lc, lit_neg, lit_var} = 6'b110000;
    tick(); tick(); tick();
    lit_valid[1] = 1'b0;
    checks++;
    if (done[1] !== 1'b0 || pass_req[1] !== 1'b0 || busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: done=%b preq=%b busy=%b, required 0 0 0",
               done[1], pass_req[1], busy[1]);
    end
  endtask

  task automatic test_edge();
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    tick();
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b1 || lit_ready[0] !== 1'b1 || pass_req[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_while_busy: busy=%b rdy=%b preq=%b, required 1 1 0",
               busy[0], lit_ready[0], pass_req[0]);
    end
    send_lit(0, 6'b100001, 1'b0);  // lone (x1), last_clause=0
    checks++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b1 || lit_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL eval_cycle: done=%b busy=%b rdy=%b, required 0 1 0",
               done[0], busy[0], lit_ready[0]);
    end
    tick();
    checks++;
    if (done[0] !== 1'b1 || sat[0] !== 1'b1 || sa_w[0] !== 4'b0010 || pc_w[0] !== 3'd1) begin
      errors++;
      $display("FAIL single_literal: done=%b sat=%b sa=%b pc=%0d, required 1 1 0010 1",
               done[0], sat[0], sa_w[0], pc_w[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_unsat();
    test_back_to_back();
    test_abort();
    test_edge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
